// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage units.
// Holds the M-extension funct3 encodings and the multiply/divide FSM states.
package riscv_pkg;

    localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per clock through a single shared adder/subtractor.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Handshake: an op is accepted on a rising edge where ready && start && !flush;
    // done pulses for one cycle with result valid, unless flush is high that cycle.
    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               neg_q, neg_rem_q;
    logic [WIDTH-1:0]   result_q;

    mdu_op_e          op_in;
    logic             accept, a_signed, b_signed, a_neg, b_neg;
    logic             div_zero, div_ovf, special;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_in    = mdu_op_e'(op);
    assign accept   = (state_q == IDLE) && start && !flush;
    assign a_signed = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU)
                   || (op_in == OP_DIV) || (op_in == OP_REM);
    assign b_signed = (op_in == OP_MUL) || (op_in == OP_MULH)
                   || (op_in == OP_DIV) || (op_in == OP_REM);
    assign a_neg    = a_signed && src_a[WIDTH-1];
    assign b_neg    = b_signed && src_b[WIDTH-1];
    assign a_mag    = a_neg ? -src_a : src_a;
    assign b_mag    = b_neg ? -src_b : src_b;
    assign div_zero = op[2] && (src_b == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM))
                   && (src_a == MIN_NEG) && (src_b == '1);
    assign special  = div_zero || div_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (accept) state_d = special ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (flush)               state_d = IDLE;
                else if (count_q == '0)  state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divide: x = {remainder, next dividend bit}, subtract divisor; carry-out means no borrow.
    // Multiply: x = upper product half, add multiplicand.
    logic             is_div;
    logic [WIDTH:0]   add_x, add_y;
    logic [WIDTH+1:0] add_sum;
    logic             qbit;
    logic [2*WIDTH-1:0] prod_step;

    assign is_div  = op_q[2];
    assign add_x   = is_div ? prod_q[2*WIDTH-1:WIDTH-1] : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    assign add_y   = is_div ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};
    assign qbit    = add_sum[WIDTH+1];

    always_comb begin
        prod_step = prod_q;
        if (is_div)
            prod_step = {(qbit ? add_sum[WIDTH-1:0] : prod_q[2*WIDTH-2:WIDTH-1]),
                         prod_q[WIDTH-2:0], qbit};
        else if (prod_q[0])
            prod_step = {add_sum[WIDTH:0], prod_q[WIDTH-1:1]};
        else
            prod_step = {1'b0, prod_q[2*WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            op_q      <= OP_MUL;
            opnd_q    <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            op_q      <= op_in;
            count_q   <= CNT_W'(WIDTH-1);
            neg_q     <= !special && (a_neg ^ b_neg);
            neg_rem_q <= !special && a_neg;
            opnd_q    <= op[2] ? b_mag : a_mag;
            // Special cases preload {remainder, quotient} so DONE selects them unchanged.
            if (div_zero)     prod_q <= {src_a, {WIDTH{1'b1}}};
            else if (div_ovf) prod_q <= {{WIDTH{1'b0}}, MIN_NEG};
            else              prod_q <= {{WIDTH{1'b0}}, (op[2] ? a_mag : b_mag)};
        end else if (state_q == CALC && !flush) begin
            prod_q  <= prod_step;
            count_q <= count_q - CNT_W'(1);
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

    assign prod_fix = neg_q ? -prod_q : prod_q;
    assign quo_fix  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

    always_comb begin
        final_res = '0;
        case (op_q)
            OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              final_res = quo_fix;
            OP_REM, OP_REMU:              final_res = rem_fix;
            default:                      final_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             result_q <= '0;
        else if (state_q == DONE && !flush)    result_q <= final_res;
    end

    assign result = (state_q == DONE && !flush) ? final_res : result_q;

endmodule
